// File: rtl/dmem_responder_if.sv
// Processor-side data memory bus: request/store fields from the master, one-cycle response strobe back.
// Latency: not applicable (signal bundle only).
// Backpressure: req is held by the master until ack; there is no other stall mechanism.
// Byte enables exist only when DMEM_BYTE_EN_EN is defined.
interface dmem_responder_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
`ifdef DMEM_BYTE_EN_EN
    logic [3:0]  be;
`endif
    logic [31:0] rdata;
    logic        ack;
    logic        err;

`ifdef DMEM_BYTE_EN_EN
    modport master (output req, we, addr, wdata, be, input rdata, ack, err);
    modport slave  (input req, we, addr, wdata, be, output rdata, ack, err);
`else
    modport master (output req, we, addr, wdata, input rdata, ack, err);
    modport slave  (input req, we, addr, wdata, output rdata, ack, err);
`endif
endinterface

// File: rtl/dmem_responder.sv
// Word-wide data memory with one memory-mapped 4-bit display register at 0x100.
// Latency: ack is high in the cycle that begins WAIT_CYCLES edges after the accepting edge.
// Backpressure: one access at a time; req is ignored outside IDLE. DMEM_BYTE_EN_EN adds byte enables.
module dmem_responder #(
    parameter int DEPTH       = 64,
    parameter int WAIT_CYCLES = 2
) (
    input  logic             clk,
    input  logic             rst,
    dmem_responder_if.slave  bus,
    output logic [3:0]       seg_digit
);
    localparam int          AW        = $clog2(DEPTH);
    localparam logic [1:0]  ST_IDLE   = 2'd0;
    localparam logic [1:0]  ST_WAIT   = 2'd1;
    localparam logic [1:0]  ST_RESP   = 2'd2;
    localparam logic [31:0] DISP_ADDR = 32'h0000_0100;
    localparam logic [31:0] MEM_BYTES = 32'(DEPTH * 4);
    localparam logic [3:0]  WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    logic [1:0]  state;
    logic [3:0]  cnt;
    logic        we_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  be_q;
    logic [31:0] mem [DEPTH];

    logic        cur_we;
    logic [31:0] cur_addr;
    logic [AW-1:0] cur_idx;
    logic        cur_disp;
    logic        cur_fault;
    logic [31:0] load_dat;
    logic        go_resp;
    logic        mem_wr;

    // With zero wait states the response is built in the accepting cycle, so the
    // live bus fields stand in for the latched copy while IDLE.
    always_comb begin
        cur_we    = (state == ST_IDLE) ? bus.we   : we_q;
        cur_addr  = (state == ST_IDLE) ? bus.addr : addr_q;
        cur_idx   = cur_addr[AW+1:2];
        cur_disp  = (cur_addr == DISP_ADDR);
        cur_fault = (cur_addr[1:0] != 2'b00) || (!cur_disp && (cur_addr >= MEM_BYTES));
        load_dat  = cur_disp ? {28'd0, seg_digit} : mem[cur_idx];
        go_resp   = ((state == ST_IDLE) && bus.req && (WAIT_CYCLES == 0)) ||
                    ((state == ST_WAIT) && (cnt == 4'd0));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= 4'd0;
            bus.ack   <= 1'b0;
            bus.err   <= 1'b0;
            bus.rdata <= 32'd0;
            seg_digit <= 4'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.req) begin
                        we_q    <= bus.we;
                        addr_q  <= bus.addr;
                        wdata_q <= bus.wdata;
                        if (WAIT_CYCLES > 0) begin
                            state <= ST_WAIT;
                            cnt   <= WAIT_LOAD;
                        end else begin
                            state <= ST_RESP;
                        end
                    end
                end
                ST_WAIT: begin
                    if (cnt == 4'd0) state <= ST_RESP;
                    else             cnt   <= cnt - 4'd1;
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                    if (we_q && !cur_fault && cur_disp && be_q[0])
                        seg_digit <= wdata_q[3:0];
                end
                default: state <= ST_IDLE;
            endcase

            if (go_resp) begin
                bus.ack   <= 1'b1;
                bus.err   <= cur_fault;
                bus.rdata <= (cur_fault || cur_we) ? 32'd0 : load_dat;
            end else if (state == ST_RESP) begin
                bus.ack   <= 1'b0;
                bus.err   <= 1'b0;
                bus.rdata <= 32'd0;
            end
        end
    end

`ifdef DMEM_BYTE_EN_EN
    always_ff @(posedge clk) begin
        if (!rst && (state == ST_IDLE) && bus.req)
            be_q <= bus.be;
    end
`else
    assign be_q = 4'hF;
`endif

    // Storage is deliberately left out of reset so contents survive it.
    assign mem_wr = !rst && (state == ST_RESP) && we_q && !cur_fault && !cur_disp;

    always_ff @(posedge clk) begin
        if (mem_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (be_q[i])
                    mem[addr_q[AW+1:2]][8*i +: 8] <= wdata_q[8*i +: 8];
            end
        end
    end
endmodule
